// File: rtl/neuron_sequencer.sv
`default_nettype none
// ==========================================================================
// neuron_sequencer : 17.15 fixed-point neuron, bias + sum(x*w), clamped ReLU
// Revision 1.0
// ==========================================================================
module neuron_sequencer #(
  parameter int N_INPUTS  = 4,
  parameter int FRAC_BITS = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] bias,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] x,
  input  logic signed [31:0] w,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] y,
  output logic               busy,
  output logic               sat
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCUM    = 2'd1,
    S_ACTIVATE = 2'd2,
    S_OUTPUT   = 2'd3
  } state_t;

  localparam logic signed [63:0] C_ACC_MAX64 = 64'sh0000_7FFF_FFFF_FFFF;
  localparam logic signed [63:0] C_ACC_MIN64 = -64'sh0000_8000_0000_0000;
  localparam logic signed [47:0] C_ACC_MAX   = 48'sh7FFF_FFFF_FFFF;
  localparam logic signed [47:0] C_ACC_MIN   = -48'sh8000_0000_0000;
  localparam logic signed [47:0] C_I32_MAX   = 48'sh0000_7FFF_FFFF;
  localparam logic signed [47:0] C_I32_MIN   = -48'sh0000_8000_0000;
  localparam logic signed [47:0] C_ONE       = 48'sh0000_0000_8000;
  localparam logic        [7:0]  C_LAST      = 8'(N_INPUTS - 1);

  state_t             state_q, state_d;
  logic signed [47:0] acc_q, acc_d;
  logic        [7:0]  count_q, count_d;
  logic               sat_q, sat_d;
  logic signed [31:0] y_q, y_d;

  logic signed [63:0] prod;
  logic signed [63:0] prod_sh;
  logic signed [63:0] sum_wide;
  logic signed [47:0] acc_sum;

  // A single term can reach +2^47, so the running sum saturates at the
  // 48-bit bounds instead of wrapping; a wrap would flip the ReLU decision.
  always_comb begin
    prod     = 64'(x) * 64'(w);
    prod_sh  = prod >>> FRAC_BITS;
    sum_wide = {{16{acc_q[47]}}, acc_q} + prod_sh;
    if (sum_wide > C_ACC_MAX64) begin
      acc_sum = C_ACC_MAX;
    end else if (sum_wide < C_ACC_MIN64) begin
      acc_sum = C_ACC_MIN;
    end else begin
      acc_sum = sum_wide[47:0];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    sat_d   = sat_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = {{16{bias[31]}}, bias};
          count_d = 8'd0;
          sat_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d   = acc_sum;
          count_d = count_q + 8'd1;
          if ((acc_sum > C_I32_MAX) || (acc_sum < C_I32_MIN)) begin
            sat_d = 1'b1;
          end
          if (count_q == C_LAST) begin
            state_d = S_ACTIVATE;
          end
        end
      end
      S_ACTIVATE: begin
        if (acc_q < 48'sd0) begin
          y_d = 32'sd0;
        end else if (acc_q > C_ONE) begin
          y_d = 32'sh0000_8000;
        end else begin
          y_d = acc_q[31:0];
        end
        state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUTPUT);
  assign busy      = (state_q != S_IDLE);
  assign sat       = sat_q;
  assign y         = y_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_neuron_sequencer : directed + randomized checks against a sum model
// Revision 1.0
// ==========================================================================
module tb_neuron_sequencer;

  localparam int N = 4;
  localparam longint A_MAX = (longint'(1) <<< 47) - 1;
  localparam longint A_MIN = -(longint'(1) <<< 47);

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [31:0] bias;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] x;
  logic signed [31:0] w;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] y;
  logic               busy;
  logic               sat;

  int checks   = 0;
  int failures = 0;

  logic [31:0] xa [N];
  logic [31:0] wa [N];

  neuron_sequencer #(.N_INPUTS(N), .FRAC_BITS(15)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: bias + sum of floor(x*w / 2^15), clamped to 48-bit range,
  // sat if any partial sum leaves int32, then ReLU capped at 1.0.
  function automatic void model(input logic [31:0] b, output logic [31:0] ey, output logic es);
    longint acc;
    longint p;
    acc = longint'($signed(b));
    es  = 1'b0;
    for (int i = 0; i < N; i++) begin
      p   = (longint'($signed(xa[i])) * longint'($signed(wa[i]))) >>> 15;
      acc = acc + p;
      if (acc > A_MAX) acc = A_MAX;
      if (acc < A_MIN) acc = A_MIN;
      if (acc > 64'sd2147483647 || acc < -64'sd2147483648) es = 1'b1;
    end
    if (acc < 0)          ey = 32'd0;
    else if (acc > 32768) ey = 32'h0000_8000;
    else                  ey = 32'(acc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gaps: 0 none, 1 idle cycle after every pair, 2 random idle cycles.
  // Idle cycles also pulse start, which must be ignored during ACCUM.
  task automatic run_eval(input logic [31:0] b, input int gaps, input int stall,
                          input bit started, input bit hold, input logic [31:0] nb);
    logic [31:0] ey;
    logic        es;
    model(b, ey, es);
    if (!started) begin
      bias  = b;
      start = 1'b1;
      tick();
    end
    start     = hold;
    bias      = $urandom;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("in_ready_accum", {31'd0, in_ready}, 32'd1);
      chk("busy_accum", {31'd0, busy}, 32'd1);
      in_valid = 1'b1;
      x = xa[i];
      w = wa[i];
      tick();
      in_valid = 1'b0;
      x = $urandom;
      w = $urandom;
      if (i < N - 1 && (gaps == 1 || (gaps == 2 && $urandom_range(0, 1) == 1))) begin
        start = 1'b1;
        tick();
        start = hold;
      end
    end
    chk("activate_out_valid", {31'd0, out_valid}, 32'd0);
    chk("activate_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("out_valid_latency", {31'd0, out_valid}, 32'd1);
    chk("y", y, ey);
    chk("sat", {31'd0, sat}, {31'd0, es});
    chk("output_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < stall; k++) begin
      tick();
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_y", y, ey);
      chk("stall_sat", {31'd0, sat}, {31'd0, es});
    end
    out_ready = 1'b1;
    if (hold) bias = nb;
    tick();
    out_ready = 1'b0;
    chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_busy", {31'd0, busy}, 32'd0);
    if (hold) begin
      tick();
      chk("held_start_restart", {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0;
    x = '0; w = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sat", {31'd0, sat}, 32'd0);
    chk("rst_y", y, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 4 x (1.0*1.0) -> acc 4.0, capped to 1.0
    for (int i = 0; i < N; i++) begin xa[i] = 32'h0000_8000; wa[i] = 32'h0000_8000; end
    run_eval(32'd0, 0, 0, 1'b0, 1'b0, 32'd0);

    // 0.5 + 0.25*1.0 -> 0.75
    xa[0] = 32'h0000_2000; wa[0] = 32'h0000_8000;
    for (int i = 1; i < N; i++) begin xa[i] = 32'd0; wa[i] = $urandom; end
    run_eval(32'h0000_4000, 0, 1, 1'b0, 1'b0, 32'd0);

    // negative sum with toggled in_valid
    for (int i = 0; i < N; i++) begin xa[i] = 32'hFFFF_8000; wa[i] = 32'h0000_4000; end
    run_eval(32'd0, 1, 0, 1'b0, 1'b0, 32'd0);

    // saturating products, output stalled 5 cycles
    for (int i = 0; i < N; i++) begin xa[i] = 32'h7FFF_FFFF; wa[i] = 32'h7FFF_FFFF; end
    run_eval(32'd0, 0, 5, 1'b0, 1'b0, 32'd0);

    // reset after two (negative) transfers; a stale acc would turn y to 0
    bias = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; x = 32'hFFFF_8000; w = 32'h0000_8000;
      tick();
    end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_sat", {31'd0, sat}, 32'd0);
    chk("midrst_y", y, 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("after_rst_no_out_valid", {31'd0, out_valid}, 32'd0);
    end
    for (int i = 0; i < N; i++) begin xa[i] = 32'h0000_8000; wa[i] = 32'h0000_2000; end
    run_eval(32'd0, 0, 0, 1'b0, 1'b0, 32'd0);

    // start held high across two evaluations
    for (int i = 0; i < N; i++) begin xa[i] = 32'h0000_4000; wa[i] = 32'h0000_4000; end
    run_eval(32'h0000_1000, 1, 1, 1'b0, 1'b1, 32'hFFFF_F000);
    for (int i = 0; i < N; i++) begin xa[i] = 32'h0000_6000; wa[i] = 32'h0000_2000; end
    run_eval(32'hFFFF_F000, 0, 0, 1'b1, 1'b0, 32'd0);
    start = 1'b0;
    tick();

    // randomized evaluations
    for (int t = 0; t < 30; t++) begin
      logic [31:0] rb;
      for (int i = 0; i < N; i++) begin
        if (t % 6 == 5) begin
          xa[i] = $urandom;
          wa[i] = $urandom;
        end else begin
          xa[i] = $urandom_range(0, 262143) - 32'd131072;
          wa[i] = $urandom_range(0, 131071) - 32'd65536;
        end
      end
      rb = $urandom_range(0, 65535) - 32'd32768;
      run_eval(rb, 2, $urandom_range(0, 3), 1'b0, 1'b0, 32'd0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
